// File: rtl/adder_rf_datapath.sv
// adder_rf_datapath: register-file datapath for the cumulative 1-to-N adder
module adder_rf_datapath #(
  parameter int DATA_W    = 8,
  parameter int LIMIT     = 10,
  parameter int CONST_VAL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RFSrcMuxSel,
  input  logic [2:0]        readAddr1,
  input  logic [2:0]        readAddr2,
  input  logic [2:0]        writeAddr,
  input  logic              writeEn,
  input  logic              outBuf,
  output logic              iLe10,
  output logic [DATA_W-1:0] outPort,
  output logic              ovf
);
  logic [7:1][DATA_W-1:0] rf_q, rf_d;
  logic [DATA_W-1:0]      a, b, wdata, out_q, out_d;
  logic [DATA_W:0]        sum;
  logic                   wr, ovf_q, ovf_d;
  // Operand reads, adder, source mux and next-state; R0 is not stored and always reads zero
  always_comb begin
    a     = (readAddr1 == 3'd0) ? '0 : rf_q[readAddr1];
    b     = (readAddr2 == 3'd0) ? '0 : rf_q[readAddr2];
    sum   = {1'b0, a} + {1'b0, b};
    wdata = RFSrcMuxSel ? sum[DATA_W-1:0] : DATA_W'(CONST_VAL);
    wr    = writeEn && (writeAddr != 3'd0);
    for (int i = 1; i < 8; i++)
      rf_d[i] = (wr && writeAddr == 3'(i)) ? wdata : rf_q[i];
    out_d = outBuf ? sum[DATA_W-1:0] : out_q;
    ovf_d = ovf_q | (wr & RFSrcMuxSel & sum[DATA_W]);
  end
  // State update; the output register samples the pre-edge sum, so no write bypass exists
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q  <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rf_q  <= rf_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end
  assign iLe10   = rf_q[1] <= DATA_W'(LIMIT);
  assign outPort = out_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_adder_rf_datapath.sv
// tb_adder_rf_datapath: directed vector bench for the adder register-file datapath
module tb_adder_rf_datapath;
  typedef struct {
    logic       sel;
    logic [2:0] ra1, ra2, wa;
    logic       we, ob;
    logic [7:0] e_out;
    logic       e_ovf, e_le;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b1;
  logic       sel = 1'b0, we = 1'b0, ob = 1'b0;
  logic [2:0] ra1 = 3'd0, ra2 = 3'd0, wa = 3'd0;
  logic       le, ovf;
  logic [7:0] outp;
  int         compared = 0, mismatched = 0;
  vec_t       vq[$];
  logic [7:0] tri_tab [11] = '{8'd0, 8'd1, 8'd3, 8'd6, 8'd10, 8'd15, 8'd21, 8'd28, 8'd36, 8'd45, 8'd55};

  adder_rf_datapath dut (
    .clk(clk), .rst(rst), .RFSrcMuxSel(sel), .readAddr1(ra1), .readAddr2(ra2),
    .writeAddr(wa), .writeEn(we), .outBuf(ob), .iLe10(le), .outPort(outp), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic [2:0] r1, r2, w, input logic e, o,
                              input logic [7:0] eo, input logic eovf, ele);
    vec_t v;
    v.sel = s; v.ra1 = r1; v.ra2 = r2; v.wa = w; v.we = e; v.ob = o;
    v.e_out = eo; v.e_ovf = eovf; v.e_le = ele;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [7:0] eo, input logic eovf, input logic ele);
    check({nm, " outPort"}, 32'(outp), 32'(eo));
    check({nm, " ovf"}, 32'(ovf), 32'(eovf));
    check({nm, " iLe10"}, 32'(le), 32'(ele));
  endtask

  task automatic apply(input vec_t v, input string nm);
    sel = v.sel; ra1 = v.ra1; ra2 = v.ra2; wa = v.wa; we = v.we; ob = v.ob;
    @(posedge clk);
    #1;
    check_all(nm, v.e_out, v.e_ovf, v.e_le);
  endtask

  initial begin
    #3;
    check_all("reset", 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Controller program: init, then loop R3<=CONST, branch, R2<=R1+R2 (outBuf), R1<=R1+R3
    vq.push_back(mk(1, 0, 0, 1, 1, 0, 8'd0, 0, 1));
    vq.push_back(mk(1, 0, 0, 2, 1, 0, 8'd0, 0, 1));
    for (int k = 0; k <= 10; k++) begin
      vq.push_back(mk(0, 0, 0, 3, 1, 0, (k == 0) ? 8'd0 : tri_tab[k-1], 0, 1));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, (k == 0) ? 8'd0 : tri_tab[k-1], 0, 1));
      vq.push_back(mk(1, 1, 2, 2, 1, 1, tri_tab[k], 0, 1));
      vq.push_back(mk(1, 1, 3, 1, 1, 0, tri_tab[k], 0, k < 10));
    end
    vq.push_back(mk(0, 0, 0, 3, 1, 0, 8'd55, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 8'd55, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 8'd55, 0, 0));
    vq.push_back(mk(1, 1, 2, 4, 0, 0, 8'd55, 0, 0));
    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("prog%0d", i));
    // R0 protection: constant write to R0 is discarded
    apply(mk(0, 0, 0, 0, 1, 0, 8'd55, 0, 0), "r0_write");
    apply(mk(1, 0, 0, 4, 0, 1, 8'd0, 0, 0), "r0_read");
    // Build R5 = 7, then read-during-write R5 <= R5+R5 with outBuf
    apply(mk(0, 0, 0, 5, 1, 0, 8'd0, 0, 0), "rdw_r5c");
    apply(mk(1, 5, 5, 6, 1, 0, 8'd0, 0, 0), "rdw_r6a");
    apply(mk(1, 5, 6, 5, 1, 0, 8'd0, 0, 0), "rdw_r5b");
    apply(mk(1, 6, 6, 6, 1, 0, 8'd0, 0, 0), "rdw_r6b");
    apply(mk(1, 5, 6, 5, 1, 1, 8'd7, 0, 0), "rdw_r5is7");
    apply(mk(1, 5, 5, 5, 1, 1, 8'd14, 0, 0), "rdw_same");
    apply(mk(1, 5, 0, 0, 0, 1, 8'd14, 0, 0), "rdw_next");
    // Overflow: R1 <= CONST then doubling; discarded carry write to R0 leaves ovf clear
    apply(mk(0, 0, 0, 1, 1, 0, 8'd14, 0, 1), "ovf_c");
    apply(mk(1, 1, 1, 1, 1, 0, 8'd14, 0, 1), "ovf_2");
    apply(mk(1, 1, 1, 1, 1, 0, 8'd14, 0, 1), "ovf_4");
    apply(mk(1, 1, 1, 1, 1, 0, 8'd14, 0, 1), "ovf_8");
    apply(mk(1, 1, 1, 1, 1, 0, 8'd14, 0, 0), "ovf_16");
    apply(mk(1, 1, 1, 1, 1, 0, 8'd14, 0, 0), "ovf_32");
    apply(mk(1, 1, 1, 1, 1, 0, 8'd14, 0, 0), "ovf_64");
    apply(mk(1, 1, 1, 1, 1, 1, 8'd128, 0, 0), "ovf_128");
    apply(mk(1, 1, 1, 0, 1, 1, 8'd0, 0, 0), "ovf_r0carry");
    apply(mk(1, 1, 1, 1, 1, 0, 8'd0, 1, 1), "ovf_wrap");
    apply(mk(0, 0, 0, 1, 1, 0, 8'd0, 1, 1), "ovf_sticky");
    // Comparator boundary: R1 = 1 stepped by R3 (= 1) up to 10, then 11
    for (int k = 2; k <= 11; k++)
      apply(mk(1, 1, 3, 1, 1, 0, 8'd0, 1, k <= 10), $sformatf("cmp_r1_%0d", k));
    apply(mk(1, 1, 5, 0, 0, 1, 8'd25, 1, 0), "pre_rst");
    // Asynchronous reset mid-cycle with nonzero state
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 1; r < 8; r++)
      apply(mk(1, 3'(r), 3'(r), 0, 0, 1, 8'd0, 0, 1), $sformatf("post_rst_r%0d", r));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
